// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared constants for the EX-stage M-extension divider. The ALU and the
// decoder use the same package.
//   XLEN          : datapath width (only 32 is supported)
//   FUNCT3_*      : funct3 encodings of DIV/DIVU/REM/REMU
//   div_state_e   : divider FSM states
//   abs_mag()     : two's-complement magnitude helper
// ---------------------------------------------------------------------------
package div_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] FUNCT3_DIV  = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU = 3'b101;
   localparam logic [2:0] FUNCT3_REM  = 3'b110;
   localparam logic [2:0] FUNCT3_REMU = 3'b111;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Magnitude of v when neg is set. The most negative value maps to itself,
   // which is still the correct unsigned magnitude (0x80000000).
   function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v,
                                                input logic            neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
// Request/response bundle between the EX-stage pipeline control (master)
// and the divider (slave).
//   request : in_valid/in_ready, funct3, a, b, tag_in
//   control : flush (kill in-flight op), busy (stall ID/EX)
//   response: out_valid/out_ready, result, tag_out
// ---------------------------------------------------------------------------
interface div_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  a;
   logic [XLEN-1:0]  b;
   logic [TAG_W-1:0] tag_in;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  result;
   logic [TAG_W-1:0] tag_out;
   logic             busy;

   modport master (
      output in_valid, funct3, a, b, tag_in, flush, out_ready,
      input  in_ready, out_valid, result, tag_out, busy
   );

   modport slave (
      input  in_valid, funct3, a, b, tag_in, flush, out_ready,
      output in_ready, out_valid, result, tag_out, busy
   );

endinterface

// File: rtl/div_iter_step.sv
// ---------------------------------------------------------------------------
// div_iter_step
// One combinational restoring shift-subtract step on {rem,quo}.
//   rem_in/quo_in   : partial remainder / quotient shift register
//   divisor         : unsigned divisor magnitude
//   rem_out/quo_out : values after shift, trial subtract and quotient bit
// ---------------------------------------------------------------------------
module div_iter_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0]   rem_sh;   // 33 bits: an unsigned remainder may reach bit 31 before the shift
   logic            trial_ge;
   logic [XLEN-1:0] trial;

   assign rem_sh   = {rem_in, quo_in[XLEN-1]};
   // The 33-bit trial subtract is non-negative exactly when rem_sh >= divisor.
   // Its difference is then below the divisor, so the low XLEN bits hold it.
   assign trial_ge = (rem_sh >= {1'b0, divisor});
   assign trial    = rem_sh[XLEN-1:0] - divisor;

   always_comb begin
      if (trial_ge) begin
         rem_out = trial;
         quo_out = {quo_in[XLEN-2:0], 1'b1};
      end else begin
         rem_out = rem_sh[XLEN-1:0];
         quo_out = {quo_in[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative radix-2 divider for DIV/DIVU/REM/REMU. One quotient bit is
// produced per cycle over 32 CALC cycles. Divide-by-zero and signed
// overflow finish in one cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_unit_if.slave (request, response, flush, busy)
// ---------------------------------------------------------------------------
module div_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic    clk,
   input  logic    rst_n,
   div_unit_if.slave bus
);

   import div_unit_pkg::*;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e       state_q, state_d;
   logic [4:0]       count_q;
   logic [XLEN-1:0]  rem_q, quo_q, dvsr_q;
   logic             sa_q, sb_q;
   logic             is_rem_q;
   logic [XLEN-1:0]  result_q;
   logic [TAG_W-1:0] tag_q;

   // Request decode, used only in the accept cycle. funct3[2] is ignored.
   logic             signed_op, sa, sb, div_zero, ovf, special, accept;
   logic [XLEN-1:0]  special_res;

   assign signed_op   = ~bus.funct3[0];
   assign sa          = signed_op & bus.a[XLEN-1];
   assign sb          = signed_op & bus.b[XLEN-1];
   assign div_zero    = (bus.b == '0);
   assign ovf         = signed_op && (bus.a == INT_MIN) && (bus.b == '1);
   assign special     = div_zero | ovf;
   assign special_res = div_zero ? (bus.funct3[1] ? bus.a : '1)
                                 : (bus.funct3[1] ? '0 : INT_MIN);
   assign accept      = (state_q == DIV_IDLE) && bus.in_valid && !bus.flush;

   // Iteration step and the sign fix-up of its final output.
   logic [XLEN-1:0] rem_nx, quo_nx, final_res;

   div_iter_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvsr_q),
      .rem_out (rem_nx),
      .quo_out (quo_nx)
   );

   // sa/sb are zero for unsigned ops, so no extra gating is needed here.
   assign final_res = is_rem_q ? (sa_q ? (~rem_nx + 1'b1) : rem_nx)
                               : ((sa_q ^ sb_q) ? (~quo_nx + 1'b1) : quo_nx);

   // Next-state logic. flush overrides everything.
   always_comb begin
      // NOTE: assign defaults first so no path leaves state_d unassigned and infers a latch.
      state_d = state_q;
      if (bus.flush) begin
         state_d = DIV_IDLE;
      end else begin
         unique case (state_q)
            DIV_IDLE: if (bus.in_valid)      state_d = special ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (count_q == 5'd31)  state_d = DIV_DONE;
            DIV_DONE: if (bus.out_ready)     state_d = DIV_IDLE;
            default:                         state_d = DIV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Datapath. Operands are sampled only at accept. result/tag stay frozen in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         is_rem_q <= 1'b0;
         result_q <= '0;
         tag_q    <= '0;
      end else if (accept) begin
         count_q  <= '0;
         rem_q    <= '0;
         quo_q    <= abs_mag(bus.a, sa);
         dvsr_q   <= abs_mag(bus.b, sb);
         sa_q     <= sa;
         sb_q     <= sb;
         is_rem_q <= bus.funct3[1];
         tag_q    <= bus.tag_in;
         if (special) result_q <= special_res;
      end else if (state_q == DIV_CALC && !bus.flush) begin
         count_q <= count_q + 5'd1;
         rem_q   <= rem_nx;
         quo_q   <= quo_nx;
         if (count_q == 5'd31) result_q <= final_res;
      end
   end

   assign bus.in_ready  = (state_q == DIV_IDLE);
   assign bus.out_valid = (state_q == DIV_DONE);
   assign bus.busy      = (state_q != DIV_IDLE);
   assign bus.result    = result_q;
   assign bus.tag_out   = tag_q;

endmodule
